// File: rtl/ts_chk32.sv
// ts_chk32: sink-side checker for the 32-bit TS word stream.
// It frames packets on ts_sync/ts_eop, checks the packet length and the header
// (sync byte, PID, continuity counter), and keeps saturating statistics plus a
// per-packet verdict pulse. There is no backpressure: one word per clk when
// ts_valid is high.
module ts_chk32 #(
    // Kept so existing instantiations still elaborate. The flops use no
    // assignment delay, so this value has no effect on the logic.
    parameter int          U_DLY     = 1,
    parameter int          PKT_WORDS = 48,
    parameter int          HDR_WORD  = 2,
    parameter logic [7:0]  SYNC_BYTE = 8'h47,
    parameter logic [12:0] EXP_PID   = 13'h0014
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        ts_sync,
    input  logic        ts_valid,
    input  logic        ts_eop,
    input  logic [31:0] ts_data,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic [31:0] good_cnt,
    output logic [15:0] len_err_cnt,
    output logic [15:0] sync_err_cnt,
    output logic [15:0] pid_err_cnt,
    output logic [15:0] cc_err_cnt,
    output logic [3:0]  last_cc,
    output logic        err_flag
);

    localparam int CW = $clog2(PKT_WORDS + 1);

    // Reject parameter sets that the framing logic cannot represent.
    if (PKT_WORDS < 2 || HDR_WORD < 1 || HDR_WORD > PKT_WORDS || U_DLY < 0) begin : g_bad_cfg
        $error("ts_chk32: invalid parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_BODY, S_DROP} state_t;

    state_t        r_state, w_nxt_state;
    logic [CW-1:0] r_word_cnt, w_cnt_nxt;
    logic          r_sync_bad, r_pid_bad, r_cc_bad;
    logic [3:0]    r_cc_ref;
    logic          r_cc_ref_valid;
    logic [3:0]    r_last_cc;
    logic          r_pkt_done, r_pkt_ok;
    logic [31:0]   r_good_cnt;
    logic [15:0]   r_len_cnt, r_sync_cnt, r_pid_cnt, r_cc_cnt;
    logic          r_err_flag;

    logic          w_start, w_restart, w_in_pkt, w_hdr_now;
    logic [CW-1:0] w_idx;
    logic [3:0]    w_cc_exp;
    logic          w_sync_now, w_pid_now, w_cc_now;
    logic          w_close, w_len_err;
    logic          w_cls_sync, w_cls_pid, w_cls_cc, w_cls_ok;
    logic          w_unused;

    // These header fields are not checked.
    assign w_unused = ^{ts_data[23:21], ts_data[7:6]};

    // A word with sync opens a packet. Inside BODY, sync together with eop is
    // taken as an eop, so that word ends the current packet and does not
    // start a new one.
    assign w_start   = ts_valid & ts_sync & ((r_state != S_BODY) | ~ts_eop);
    assign w_restart = w_start & (r_state == S_BODY);
    assign w_idx     = w_start ? CW'(1) : r_word_cnt + CW'(1);
    assign w_in_pkt  = w_start | (ts_valid & (r_state == S_BODY));
    assign w_hdr_now = w_in_pkt & (w_idx == CW'(HDR_WORD));

    // Header checks on the word being accepted in this cycle.
    assign w_cc_exp   = ts_data[4] ? r_cc_ref + 4'd1 : r_cc_ref;
    assign w_sync_now = w_hdr_now & (ts_data[31:24] != SYNC_BYTE);
    assign w_pid_now  = w_hdr_now & (ts_data[20:8] != EXP_PID);
    assign w_cc_now   = w_hdr_now & r_cc_ref_valid & (ts_data[3:0] != w_cc_exp);

    // Verdict of the packet being closed. On a restart the current word
    // belongs to the new packet, so only the stored flags apply. On a
    // single-word packet seen in IDLE/DROP, only the current word applies.
    assign w_cls_sync = ((r_state == S_BODY) & r_sync_bad) | (~w_restart & w_sync_now);
    assign w_cls_pid  = ((r_state == S_BODY) & r_pid_bad)  | (~w_restart & w_pid_now);
    assign w_cls_cc   = ((r_state == S_BODY) & r_cc_bad)   | (~w_restart & w_cc_now);
    assign w_cls_ok   = ~(w_len_err | w_cls_sync | w_cls_pid | w_cls_cc);

    // Framing state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nxt_state;
    end

    // Framing next state, word count and close decision.
    always_comb begin
        w_nxt_state = r_state;
        w_cnt_nxt   = r_word_cnt;
        w_close     = 1'b0;
        w_len_err   = 1'b0;
        case (r_state)
            S_IDLE, S_DROP: begin
                if (w_start) begin
                    if (ts_eop) begin
                        w_close     = 1'b1;
                        w_len_err   = 1'b1;
                        w_nxt_state = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_nxt_state = S_BODY;
                        w_cnt_nxt   = CW'(1);
                    end
                end
            end
            S_BODY: begin
                if (ts_valid) begin
                    if (ts_eop) begin
                        w_close     = 1'b1;
                        w_len_err   = (r_word_cnt + CW'(1)) != CW'(PKT_WORDS);
                        w_nxt_state = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (ts_sync) begin
                        w_close   = 1'b1;
                        w_len_err = 1'b1;
                        w_cnt_nxt = CW'(1);
                    end else if ((r_word_cnt + CW'(1)) == CW'(PKT_WORDS)) begin
                        w_close     = 1'b1;
                        w_len_err   = 1'b1;
                        w_nxt_state = S_DROP;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_word_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Word counter and per-packet header flags. The flags are cleared when a
    // packet starts and loaded when its header word arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_cnt <= '0;
            r_sync_bad <= 1'b0;
            r_pid_bad  <= 1'b0;
            r_cc_bad   <= 1'b0;
        end else begin
            r_word_cnt <= w_cnt_nxt;
            if (w_start | w_hdr_now) begin
                r_sync_bad <= w_sync_now;
                r_pid_bad  <= w_pid_now;
                r_cc_bad   <= w_cc_now;
            end
        end
    end

    // Continuity reference: follows every received CC. clr drops its validity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cc_ref       <= 4'd0;
            r_cc_ref_valid <= 1'b0;
            r_last_cc      <= 4'd0;
        end else begin
            if (w_hdr_now) begin
                r_cc_ref  <= ts_data[3:0];
                r_last_cc <= ts_data[3:0];
            end
            if (clr)            r_cc_ref_valid <= 1'b0;
            else if (w_hdr_now) r_cc_ref_valid <= 1'b1;
        end
    end

    // Verdict pulse, one cycle after the closing word. clr does not affect it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_done <= 1'b0;
            r_pkt_ok   <= 1'b0;
        end else begin
            r_pkt_done <= w_close;
            r_pkt_ok   <= w_close & w_cls_ok;
        end
    end

    function automatic logic [15:0] sat16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    function automatic logic [31:0] sat32(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    // Saturating statistics and sticky error flag. A clr in the same cycle as
    // a close discards that close's update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_good_cnt <= '0;
            r_len_cnt  <= '0;
            r_sync_cnt <= '0;
            r_pid_cnt  <= '0;
            r_cc_cnt   <= '0;
            r_err_flag <= 1'b0;
        end else if (clr) begin
            r_good_cnt <= '0;
            r_len_cnt  <= '0;
            r_sync_cnt <= '0;
            r_pid_cnt  <= '0;
            r_cc_cnt   <= '0;
            r_err_flag <= 1'b0;
        end else if (w_close) begin
            r_good_cnt <= sat32(r_good_cnt, w_cls_ok);
            r_len_cnt  <= sat16(r_len_cnt,  w_len_err);
            r_sync_cnt <= sat16(r_sync_cnt, w_cls_sync);
            r_pid_cnt  <= sat16(r_pid_cnt,  w_cls_pid);
            r_cc_cnt   <= sat16(r_cc_cnt,   w_cls_cc);
            if (!w_cls_ok) r_err_flag <= 1'b1;
        end
    end

    assign pkt_done     = r_pkt_done;
    assign pkt_ok       = r_pkt_ok;
    assign good_cnt     = r_good_cnt;
    assign len_err_cnt  = r_len_cnt;
    assign sync_err_cnt = r_sync_cnt;
    assign pid_err_cnt  = r_pid_cnt;
    assign cc_err_cnt   = r_cc_cnt;
    assign last_cc      = r_last_cc;
    assign err_flag     = r_err_flag;

endmodule
